// File: rtl/desc_word_sender.sv
// Descriptor-load transmitter: packs 8-bit descriptor pixels into 32-bit words
// and hands them to the NCC array through a small word FIFO with ready/ack.
module desc_word_sender #(
  parameter int unsigned NUM_PIXELS = 256,
  parameter int unsigned FIFO_DEPTH = 2,
  localparam int unsigned NUM_WORDS = NUM_PIXELS / 4,
  localparam int unsigned WC_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [7:0]      pix_in,
  input  logic            pix_valid,
  output logic            pix_ready,
  output logic [31:0]     desc_data_out,
  output logic            desc_data_ready,
  input  logic            desc_data_ack,
  output logic            busy,
  output logic            desc_done,
  output logic [WC_W-1:0] word_count
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [WC_W-1:0]  LAST_WORD = WC_W'(NUM_WORDS - 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, PACK, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       lane_q, lane_d;
  logic [23:0]      pack_q, pack_d;      // lanes 0-2; lane 3 goes straight to the FIFO
  logic [WC_W-1:0]  pushed_q, pushed_d;  // pixel counter in word units (lane_q holds the low bits)
  logic [WC_W-1:0]  acked_q, acked_d;
  logic [31:0]      mem_q [FIFO_DEPTH];
  logic [31:0]      mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      last_q, last_d;

  logic fifo_empty, fifo_full, pop, accept, push;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == FULL_CNT);
  assign pop        = ~fifo_empty & desc_data_ack;
  assign pix_ready  = (state_q == PACK) & ((lane_q != 2'd3) | ~fifo_full | pop);
  assign accept     = pix_valid & pix_ready;
  assign push       = accept & (lane_q == 2'd3);

  // Last popped word is shown while the FIFO is empty so the bus never shows stale slots.
  assign desc_data_out   = fifo_empty ? last_q : mem_q[rd_ptr_q];
  assign desc_data_ready = ~fifo_empty;
  assign busy            = (state_q != IDLE);
  assign desc_done       = (state_q == DONE);
  assign word_count      = acked_q;

  always_comb begin
    state_d  = state_q;
    lane_d   = lane_q;
    pack_d   = pack_q;
    pushed_d = pushed_q;
    acked_d  = acked_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    last_d   = last_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = PACK;
          lane_d   = '0;
          pushed_d = '0;
          acked_d  = '0;
        end
      end
      PACK: begin
        if (push && (pushed_q == LAST_WORD)) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && (acked_q == LAST_WORD)) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      lane_d = lane_q + 2'd1;
      unique case (lane_q)
        2'd0: pack_d[23:16] = pix_in;
        2'd1: pack_d[15:8]  = pix_in;
        2'd2: pack_d[7:0]   = pix_in;
        default: begin
          mem_d[wr_ptr_q] = {pack_q, pix_in};
          wr_ptr_d        = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
          pushed_d        = (pushed_q == LAST_WORD) ? '0 : pushed_q + WC_W'(1);
        end
      endcase
    end

    if (pop) begin
      last_d   = mem_q[rd_ptr_q];
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
      acked_d  = (acked_q == LAST_WORD) ? '0 : acked_q + WC_W'(1);
    end

    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      lane_q   <= '0;
      pack_q   <= '0;
      pushed_q <= '0;
      acked_q  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      pack_q   <= pack_d;
      pushed_q <= pushed_d;
      acked_q  <= acked_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
    end
  end

endmodule

// File: tb/tb_desc_word_sender.sv
// Directed bench for desc_word_sender: nominal, sparse, backpressure, full push/pop,
// mid-transfer reset and illegal start/ack events.
module tb_desc_word_sender;

  localparam int NP = 256;
  localparam int NW = 64;

  logic        clk, rst, start;
  logic [7:0]  pix_in;
  logic        pix_valid, pix_ready;
  logic [31:0] desc_data_out;
  logic        desc_data_ready, desc_data_ack, busy, desc_done;
  logic [5:0]  word_count;

  int total = 0;
  int bad   = 0;

  logic [31:0] got[$];
  int          done_cnt, done_cyc, last_ack_cyc, ncyc;
  bit          tr_prdy [4096];
  bit          tr_dr   [4096];
  bit          tr_ack  [4096];
  bit          tr_acc  [4096];
  logic [31:0] tr_do   [4096];
  int          tr_npix [4096];
  logic [5:0]  tr_wc   [4096];

  desc_word_sender #(.NUM_PIXELS(NP), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .start(start), .pix_in(pix_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .desc_data_out(desc_data_out), .desc_data_ready(desc_data_ready),
    .desc_data_ack(desc_data_ack), .busy(busy), .desc_done(desc_done), .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_word(input int n);
    logic [7:0] b0;
    b0 = 8'(4 * n);
    return {b0, b0 + 8'd1, b0 + 8'd2, b0 + 8'd3};
  endfunction

  // Runs one descriptor cycle by cycle and records a per-cycle trace.
  task automatic stream(input bit do_start, input bit sparse, input int stall, input int max_pix);
    int npix, stall_seen;
    bit tog;
    got.delete();
    done_cnt = 0; done_cyc = -1; last_ack_cyc = -1; ncyc = 0;
    npix = 0; stall_seen = 0; tog = 1'b0;
    if (do_start) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int c = 0; c < 4000; c++) begin
      pix_valid     = (npix < max_pix) && (!sparse || tog);
      tog           = ~tog;
      pix_in        = 8'(npix);
      desc_data_ack = (stall_seen >= stall);
      @(negedge clk);
      tr_prdy[c] = pix_ready;
      tr_dr[c]   = desc_data_ready;
      tr_ack[c]  = desc_data_ack;
      tr_do[c]   = desc_data_out;
      tr_npix[c] = npix;
      tr_wc[c]   = word_count;
      tr_acc[c]  = pix_valid && pix_ready;
      if (pix_valid && pix_ready) npix++;
      if (desc_data_ready && desc_data_ack) begin
        got.push_back(desc_data_out);
        last_ack_cyc = c;
      end
      if (desc_data_ready && !desc_data_ack) stall_seen++;
      if (desc_done) begin
        done_cnt++;
        done_cyc = c;
      end
      @(posedge clk); #1;
      ncyc = c + 1;
      if (done_cyc >= 0 || (max_pix < NP && npix >= max_pix)) break;
    end
    pix_valid     = 1'b0;
    desc_data_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; pix_valid = 1'b1; pix_in = 8'hAA; desc_data_ack = 1'b1;
    @(posedge clk); #1;
    total++; if (pix_ready !== 1'b0) begin bad++; $display("FAIL reset_pix_ready got=%b exp=0", pix_ready); end
    total++; if (desc_data_out !== 32'h0) begin bad++; $display("FAIL reset_data got=%h exp=00000000", desc_data_out); end
    total++; if (desc_data_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", desc_data_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (desc_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", desc_done); end
    total++; if (word_count !== 6'd0) begin bad++; $display("FAIL reset_wc got=%0d exp=0", word_count); end
    start = 1'b0; pix_valid = 1'b0; desc_data_ack = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_nominal();
    int c4;
    stream(1'b1, 1'b0, 0, NP);
    total++; if (got.size() !== NW) begin bad++; $display("FAIL nom_count got=%0d exp=%0d", got.size(), NW); end
    foreach (got[i]) begin
      total++; if (got[i] !== exp_word(i)) begin bad++; $display("FAIL nom_word%0d got=%h exp=%h", i, got[i], exp_word(i)); end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL nom_done_cnt got=%0d exp=1", done_cnt); end
    total++; if (done_cyc !== last_ack_cyc + 1) begin bad++; $display("FAIL nom_done_time got=%0d exp=%0d", done_cyc, last_ack_cyc + 1); end
    total++; if (word_count !== 6'd0) begin bad++; $display("FAIL nom_wc_end got=%0d exp=0", word_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL nom_busy_end got=%b exp=0", busy); end
    c4 = -1;
    for (int c = 0; c < ncyc; c++) if (tr_acc[c] && tr_npix[c] == 3 && c4 < 0) c4 = c;
    total++; if (c4 !== 3) begin bad++; $display("FAIL nom_4th_pix_cyc got=%0d exp=3", c4); end
    if (c4 < 0) c4 = 0;
    total++; if (tr_dr[c4] !== 1'b0) begin bad++; $display("FAIL nom_ready_early got=%b exp=0", tr_dr[c4]); end
    total++; if (tr_dr[c4+1] !== 1'b1 || tr_do[c4+1] !== 32'h00010203) begin
      bad++; $display("FAIL nom_first_latency got=%b/%h exp=1/00010203", tr_dr[c4+1], tr_do[c4+1]); end
    total++; if (tr_wc[c4+2] !== 6'd1) begin bad++; $display("FAIL nom_wc_after1 got=%0d exp=1", tr_wc[c4+2]); end
  endtask

  task automatic test_sparse();
    int c4;
    stream(1'b1, 1'b1, 0, NP);
    total++; if (got.size() !== NW) begin bad++; $display("FAIL sparse_count got=%0d exp=%0d", got.size(), NW); end
    foreach (got[i]) begin
      total++; if (got[i] !== exp_word(i)) begin bad++; $display("FAIL sparse_word%0d got=%h exp=%h", i, got[i], exp_word(i)); end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL sparse_done_cnt got=%0d exp=1", done_cnt); end
    c4 = -1;
    for (int c = 0; c < ncyc; c++) if (tr_acc[c] && tr_npix[c] == 3 && c4 < 0) c4 = c;
    total++; if (c4 !== 7) begin bad++; $display("FAIL sparse_4th_pix_cyc got=%0d exp=7", c4); end
    if (c4 < 0) c4 = 0;
    total++; if (tr_dr[c4] !== 1'b0) begin bad++; $display("FAIL sparse_ready_early got=%b exp=0", tr_dr[c4]); end
    total++; if (tr_dr[c4+1] !== 1'b1 || tr_do[c4+1] !== 32'h00010203) begin
      bad++; $display("FAIL sparse_first_latency got=%b/%h exp=1/00010203", tr_dr[c4+1], tr_do[c4+1]); end
  endtask

  task automatic test_backpressure();
    stream(1'b1, 1'b0, 10, NP);
    // word0 visible at cycle 4, held unacked through cycle 13
    for (int c = 4; c < 14; c++) begin
      total++; if (tr_dr[c] !== 1'b1 || tr_do[c] !== 32'h00010203) begin
        bad++; $display("FAIL bp_hold_c%0d got=%b/%h exp=1/00010203", c, tr_dr[c], tr_do[c]); end
    end
    total++; if (tr_npix[13] !== 11) begin bad++; $display("FAIL bp_pix_accepted got=%0d exp=11", tr_npix[13]); end
    total++; if (tr_prdy[13] !== 1'b0) begin bad++; $display("FAIL bp_pix_ready got=%b exp=0", tr_prdy[13]); end
    total++; if (tr_prdy[10] !== 1'b1) begin bad++; $display("FAIL bp_lane2_ready got=%b exp=1", tr_prdy[10]); end
    total++; if (got.size() !== NW) begin bad++; $display("FAIL bp_count got=%0d exp=%0d", got.size(), NW); end
    foreach (got[i]) begin
      total++; if (got[i] !== exp_word(i)) begin bad++; $display("FAIL bp_word%0d got=%h exp=%h", i, got[i], exp_word(i)); end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL bp_done_cnt got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_full_pushpop();
    int r;
    stream(1'b1, 1'b0, 10, NP);
    r = -1;
    for (int c = 0; c < ncyc; c++) if (tr_dr[c] && tr_ack[c] && r < 0) r = c;
    total++; if (r !== 14) begin bad++; $display("FAIL fpp_resume_cyc got=%0d exp=14", r); end
    if (r < 0) r = 0;
    total++; if (tr_prdy[r] !== 1'b1 || tr_acc[r] !== 1'b1) begin
      bad++; $display("FAIL fpp_lane3_accept got=%b/%b exp=1/1", tr_prdy[r], tr_acc[r]); end
    total++; if (tr_dr[r+1] !== 1'b1 || tr_do[r+1] !== 32'h04050607) begin
      bad++; $display("FAIL fpp_next1 got=%b/%h exp=1/04050607", tr_dr[r+1], tr_do[r+1]); end
    total++; if (tr_dr[r+2] !== 1'b1 || tr_do[r+2] !== 32'h08090A0B) begin
      bad++; $display("FAIL fpp_next2 got=%b/%h exp=1/08090a0b", tr_dr[r+2], tr_do[r+2]); end
    total++; if (got.size() !== NW) begin bad++; $display("FAIL fpp_count got=%0d exp=%0d", got.size(), NW); end
  endtask

  task automatic test_reset_mid();
    stream(1'b1, 1'b0, 0, 37);
    total++; if (word_count !== 6'd9) begin bad++; $display("FAIL rm_wc_before got=%0d exp=9", word_count); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rm_busy_before got=%b exp=1", busy); end
    #2 rst = 1'b0;
    #1;
    total++; if (pix_ready !== 1'b0) begin bad++; $display("FAIL rm_pix_ready got=%b exp=0", pix_ready); end
    total++; if (desc_data_out !== 32'h0) begin bad++; $display("FAIL rm_data got=%h exp=00000000", desc_data_out); end
    total++; if (desc_data_ready !== 1'b0) begin bad++; $display("FAIL rm_ready got=%b exp=0", desc_data_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b exp=0", busy); end
    total++; if (word_count !== 6'd0) begin bad++; $display("FAIL rm_wc got=%0d exp=0", word_count); end
    total++; if (desc_done !== 1'b0) begin bad++; $display("FAIL rm_done got=%b exp=0", desc_done); end
    @(posedge clk); #1;
    total++; if (desc_data_ready !== 1'b0) begin bad++; $display("FAIL rm_fifo_empty got=%b exp=0", desc_data_ready); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    stream(1'b1, 1'b0, 0, NP);
    total++; if (got.size() !== NW) begin bad++; $display("FAIL rm_count got=%0d exp=%0d", got.size(), NW); end
    foreach (got[i]) begin
      total++; if (got[i] !== exp_word(i)) begin bad++; $display("FAIL rm_word%0d got=%h exp=%h", i, got[i], exp_word(i)); end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL rm_done_cnt got=%0d exp=1", done_cnt); end
  endtask

  task automatic test_illegal();
    pix_valid = 1'b1; pix_in = 8'h55; desc_data_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++; if (pix_ready !== 1'b0) begin bad++; $display("FAIL il_idle_pix_ready got=%b exp=0", pix_ready); end
      total++; if (word_count !== 6'd0 || desc_data_ready !== 1'b0) begin
        bad++; $display("FAIL il_idle_ack got=%0d/%b exp=0/0", word_count, desc_data_ready); end
      total++; if (desc_data_out !== 32'hFCFDFEFF) begin bad++; $display("FAIL il_idle_hold got=%h exp=fcfdfeff", desc_data_out); end
      @(posedge clk); #1;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; pix_valid = 1'b0; desc_data_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) start = 1'b1;
      @(negedge clk);
      total++; if (busy !== 1'b1 || desc_done !== 1'b0) begin
        bad++; $display("FAIL il_pack_state got=%b/%b exp=1/0", busy, desc_done); end
      total++; if (word_count !== 6'd0 || desc_data_ready !== 1'b0) begin
        bad++; $display("FAIL il_pack_ack got=%0d/%b exp=0/0", word_count, desc_data_ready); end
      @(posedge clk); #1;
      start = 1'b0;
    end
    stream(1'b0, 1'b0, 0, NP);
    total++; if (got.size() !== NW) begin bad++; $display("FAIL il_count got=%0d exp=%0d", got.size(), NW); end
    foreach (got[i]) begin
      total++; if (got[i] !== exp_word(i)) begin bad++; $display("FAIL il_word%0d got=%h exp=%h", i, got[i], exp_word(i)); end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL il_done_cnt got=%0d exp=1", done_cnt); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if (desc_done !== 1'b0 || busy !== 1'b0) begin
        bad++; $display("FAIL il_after_done got=%b/%b exp=0/0", desc_done, busy); end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_sparse();
    test_backpressure();
    test_full_pushpop();
    test_reset_mid();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
